// File: rtl/square_loop_sequencer_pkg.sv
// Shared types for the squaring-loop sequencer: FSM state encoding and
// operand-source select values.
package sq_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    FLUSH,
    DONE
  } state_t;

  localparam logic OP_SEL_SEED     = 1'b0;
  localparam logic OP_SEL_FEEDBACK = 1'b1;

endpackage

// File: rtl/square_loop_sequencer_tracker.sv
// Tracks the single in-flight launch through the fixed-latency squaring pipe.
// A launch on in_valid at cycle t appears on out_valid at cycle t+PIPE_LAT.
module pipe_valid_tracker #(
  parameter int unsigned PIPE_LAT = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_valid,
  output logic out_valid,
  output logic any_inflight
);

  logic [PIPE_LAT-1:0] sr;

  // Shift form avoids a negative-range slice when PIPE_LAT is 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '0;
    end else begin
      sr <= (sr << 1) | PIPE_LAT'(in_valid);
    end
  end

  assign out_valid    = sr[PIPE_LAT-1];
  assign any_inflight = |sr;

endmodule

// File: rtl/square_loop_sequencer.sv
// Sequences T back-to-back squarings of one operand through the fixed-latency
// datapath: selects the operand source, launches, captures, and hands off.
module square_loop_sequencer
  import sq_seq_pkg::*;
#(
  parameter int unsigned PIPE_LAT = 5,
  parameter int unsigned T_LEN    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             start_ready,
  input  logic [T_LEN-1:0] num_iter,
  input  logic             abort,
  output logic             op_sel,
  output logic             op_valid,
  output logic             cap_en,
  output logic [T_LEN-1:0] iter_count,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready
);

  state_t           state;
  logic [T_LEN-1:0] num_iter_q;
  logic [T_LEN-1:0] cnt_next;
  logic             any_inflight;

  pipe_valid_tracker #(
    .PIPE_LAT(PIPE_LAT)
  ) u_tracker (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (op_valid),
    .out_valid    (cap_en),
    .any_inflight (any_inflight)
  );

  always_comb begin
    cnt_next = (iter_count == '1) ? iter_count : iter_count + T_LEN'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      start_ready <= 1'b1;
      op_sel      <= OP_SEL_SEED;
      op_valid    <= 1'b0;
      busy        <= 1'b0;
      done_valid  <= 1'b0;
      iter_count  <= '0;
      num_iter_q  <= '0;
    end else begin
      op_valid <= 1'b0;
      if (cap_en) begin
        iter_count <= cnt_next;
      end

      case (state)
        IDLE: begin
          if (start) begin
            num_iter_q  <= num_iter;
            iter_count  <= '0;
            busy        <= 1'b1;
            start_ready <= 1'b0;
            if (num_iter == '0) begin
              state      <= DONE;
              done_valid <= 1'b1;
            end else begin
              op_sel   <= OP_SEL_SEED;
              op_valid <= 1'b1;
              state    <= LAUNCH;
            end
          end
        end

        LAUNCH: begin
          state <= abort ? FLUSH : WAIT;
        end

        // Completion is checked before abort so a run finishing on the
        // abort cycle still reports its result.
        WAIT: begin
          if (cap_en && (cnt_next == num_iter_q)) begin
            state      <= DONE;
            done_valid <= 1'b1;
          end else if (abort) begin
            state <= FLUSH;
          end else if (cap_en) begin
            op_sel   <= OP_SEL_FEEDBACK;
            op_valid <= 1'b1;
            state    <= LAUNCH;
          end
        end

        FLUSH: begin
          if (!any_inflight) begin
            state       <= IDLE;
            busy        <= 1'b0;
            start_ready <= 1'b1;
          end
        end

        DONE: begin
          if (done_ready) begin
            state       <= IDLE;
            done_valid  <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
